// File: rtl/morph_frame_ctrl_if.sv
// Video timing strobes and configuration handshake shared between a frame source and morph_frame_ctrl.
interface morph_frame_ctrl_if;
  logic       pre_frame_vsync;
  logic       pre_frame_hsync;
  logic       pre_frame_valid;
  logic [2:0] cfg_mode;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (
    output pre_frame_vsync,
    output pre_frame_hsync,
    output pre_frame_valid,
    output cfg_mode,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  pre_frame_vsync,
    input  pre_frame_hsync,
    input  pre_frame_valid,
    input  cfg_mode,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer for a two-stage morphology pipeline: latches one pending mode, applies it at frame start,
// tracks line/pixel counts and drains the pipeline. Define MORPH_FRAME_CTRL_ERRCHK_EN to build the sticky error checks.
module morph_frame_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int FLUSH_CYC = 1288
) (
  input  logic                 clk,
  input  logic                 rst_n,
  morph_frame_ctrl_if.slave    bus,
  output logic [1:0]           stg1_sel,
  output logic [1:0]           stg2_sel,
  output logic                 busy,
  output logic                 frame_done,
  output logic [9:0]           line_cnt,
  output logic [10:0]          pix_cnt,
  output logic [2:0]           err_stat,
  input  logic                 err_clr
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic          smp_vld_q, smp_vld_d;
  logic          pend_full_q, pend_full_d;
  logic [2:0]    pend_mode_q, pend_mode_d;
  logic [1:0]    stg1_q, stg1_d;
  logic [1:0]    stg2_q, stg2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [9:0]    line_q, line_d;
  logic [10:0]   pix_q, pix_d;
  logic [FW-1:0] flush_q, flush_d;

  logic          vs_rise;
  logic          vs_fall;
  logic          hs_fall;
  logic          cfg_hs;
  logic          cfg_legal;
  logic          pix_inc;
  logic          line_inc;
  logic          apply;
  logic [10:0]   pix_final;
  logic [9:0]    line_final;
  logic [3:0]    sel_map;

  // smp_vld_q stays low for the first clock after reset so a vsync already high is not taken as a rising edge
  assign vs_rise   = bus.pre_frame_vsync & ~vsync_q & smp_vld_q;
  assign vs_fall   = ~bus.pre_frame_vsync & vsync_q;
  assign hs_fall   = ~bus.pre_frame_hsync & hsync_q;
  assign cfg_hs    = bus.cfg_valid & ~pend_full_q;
  assign cfg_legal = (bus.cfg_mode <= 3'd4);

  function automatic logic [3:0] map_sel(input logic [2:0] mode);
    case (mode)
      3'd1:    return 4'b01_00;
      3'd2:    return 4'b10_00;
      3'd3:    return 4'b10_01;
      3'd4:    return 4'b01_10;
      default: return 4'b00_00;
    endcase
  endfunction

  assign sel_map = map_sel(pend_mode_q);

  always_comb begin
    state_d     = state_q;
    vsync_d     = bus.pre_frame_vsync;
    hsync_d     = bus.pre_frame_hsync;
    smp_vld_d   = 1'b1;
    pend_full_d = pend_full_q;
    pend_mode_d = pend_mode_q;
    stg1_d      = stg1_q;
    stg2_d      = stg2_q;
    done_d      = 1'b0;
    flush_d     = flush_q;
    apply       = 1'b0;

    pix_inc    = (state_q == ST_ACTIVE) & bus.pre_frame_hsync & bus.pre_frame_valid;
    pix_final  = (pix_inc && (pix_q != 11'h7FF)) ? pix_q + 11'd1 : pix_q;
    line_inc   = (state_q == ST_ACTIVE) & hs_fall;
    line_final = (line_inc && (line_q != 10'h3FF)) ? line_q + 10'd1 : line_q;
    pix_d      = hs_fall ? 11'd0 : pix_final;
    line_d     = line_final;

    case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          state_d = ST_ACTIVE;
          apply   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vs_fall) begin
          state_d = ST_FLUSH;
          flush_d = FW'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        // A new frame arriving during the drain takes priority over the countdown
        if (vs_rise) begin
          state_d = ST_ACTIVE;
          done_d  = 1'b1;
          apply   = 1'b1;
        end else if (flush_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      line_d = 10'd0;
      pix_d  = 11'd0;
      if (pend_full_q) begin
        stg1_d      = sel_map[3:2];
        stg2_d      = sel_map[1:0];
        pend_full_d = 1'b0;
      end
    end

    // The slot is cleared before refill so a handshake on the activating edge waits for the next frame
    if (cfg_hs && cfg_legal) begin
      pend_full_d = 1'b1;
      pend_mode_d = bus.cfg_mode;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      smp_vld_q   <= 1'b0;
      pend_full_q <= 1'b0;
      pend_mode_q <= 3'd0;
      stg1_q      <= 2'b00;
      stg2_q      <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      line_q      <= 10'd0;
      pix_q       <= 11'd0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      smp_vld_q   <= smp_vld_d;
      pend_full_q <= pend_full_d;
      pend_mode_q <= pend_mode_d;
      stg1_q      <= stg1_d;
      stg2_q      <= stg2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      line_q      <= line_d;
      pix_q       <= pix_d;
      flush_q     <= flush_d;
    end
  end

`ifdef MORPH_FRAME_CTRL_ERRCHK_EN
  logic [2:0] err_q, err_d;

  // Error events are ORed in after the clear so a same-cycle event survives err_clr
  always_comb begin
    err_d = err_clr ? 3'b000 : err_q;
    if (line_inc && (pix_final != 11'(IMG_W))) err_d[0] = 1'b1;
    if ((state_q == ST_ACTIVE) && vs_fall && (line_final != 10'(IMG_H))) err_d[1] = 1'b1;
    if (cfg_hs && !cfg_legal) err_d[2] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 3'b000;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_stat = err_q;
`else
  localparam int unused_dims = IMG_W + IMG_H;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_stat       = 3'b000;
`endif

  assign bus.cfg_ready = ~pend_full_q;
  assign stg1_sel      = stg1_q;
  assign stg2_sel      = stg2_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign line_cnt      = line_q;
  assign pix_cnt       = pix_q;

endmodule
